// File: rtl/dual_track_counter.sv
// Multi-channel up/down counter carrying an architectural value v and an
// independently updated shadow imp; v + imp == MAX is checked every cycle.
module dtc_lane #(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0,
  parameter int RESET_V  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] imp,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             edge_p,
  output logic             bad
);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] RV  = WIDTH'(RESET_V);

  logic [WIDTH-1:0] v_n, imp_n;
  logic             bnd_n;

  // imp moves opposite to v from its own register, never recomputed from v
  always_comb begin
    v_n   = v;
    imp_n = imp;
    bnd_n = 1'b0;
    if (ld) begin
      v_n   = ld_val;
      imp_n = MAX - ld_val;
    end else if (en) begin
      if (dir) begin
        if (v == MAX) begin
          bnd_n = 1'b1;
          if (SATURATE == 0) begin
            v_n   = '0;
            imp_n = MAX;
          end
        end else begin
          v_n   = v + ONE;
          imp_n = imp - ONE;
        end
      end else begin
        if (v == '0) begin
          bnd_n = 1'b1;
          if (SATURATE == 0) begin
            v_n   = MAX;
            imp_n = '0;
          end
        end else begin
          v_n   = v - ONE;
          imp_n = imp + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v      <= RV;
      imp    <= MAX - RV;
      out_q  <= RV;
      edge_p <= 1'b0;
    end else begin
      v      <= v_n;
      imp    <= imp_n;
      out_q  <= out;
      edge_p <= bnd_n;
    end
  end

  assign out = v & (MAX - imp);
  assign bad = (v + imp) != MAX;
endmodule

module dual_track_counter #(
  parameter int WIDTH    = 4,
  parameter int NCH      = 2,
  parameter int SATURATE = 0,
  parameter int RESET_V  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       dir,
  input  logic [NCH-1:0]       ld,
  input  logic [NCH*WIDTH-1:0] ld_val,
  output logic [NCH*WIDTH-1:0] out,
  output logic [NCH*WIDTH-1:0] out_q,
  output logic [NCH*WIDTH-1:0] v_o,
  output logic [NCH*WIDTH-1:0] imp_o,
  output logic [NCH-1:0]       edge_p,
  output logic                 inv_err
);
  logic [NCH-1:0][WIDTH-1:0] ldv, v, imp, o, oq;
  logic [NCH-1:0]            bad;

  assign ldv = ld_val;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    dtc_lane #(.WIDTH(WIDTH), .SATURATE(SATURATE), .RESET_V(RESET_V)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (en[c]),
      .dir    (dir[c]),
      .ld     (ld[c]),
      .ld_val (ldv[c]),
      .v      (v[c]),
      .imp    (imp[c]),
      .out    (o[c]),
      .out_q  (oq[c]),
      .edge_p (edge_p[c]),
      .bad    (bad[c])
    );
  end

  assign v_o   = v;
  assign imp_o = imp;
  assign out   = o;
  assign out_q = oq;

  // sticky until reset; only a broken datapath can ever set it
  always_ff @(posedge clk) begin
    if (rst)       inv_err <= 1'b0;
    else if (|bad) inv_err <= 1'b1;
  end
endmodule

// File: tb/tb_dual_track_counter.sv
// Scoreboard bench: a wrap and a saturate 4-bit/2-channel instance share
// directed stimulus; an 8-bit/3-channel instance takes random stimulus.
module tb_dual_track_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  en, dir, ld;
  logic [7:0]  ld_val;
  logic [2:0]  en_c, dir_c, ld_c;
  logic [23:0] ld_val_c;

  logic [7:0]  out_a, out_q_a, v_a, imp_a, out_b, out_q_b, v_b, imp_b;
  logic [1:0]  edge_a, edge_b;
  logic        inv_a, inv_b, inv_c;
  logic [23:0] out_c, out_q_c, v_c, imp_c;
  logic [2:0]  edge_c;

  dual_track_counter #(.WIDTH(4), .NCH(2), .SATURATE(0), .RESET_V(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .ld(ld), .ld_val(ld_val),
    .out(out_a), .out_q(out_q_a), .v_o(v_a), .imp_o(imp_a), .edge_p(edge_a), .inv_err(inv_a));
  dual_track_counter #(.WIDTH(4), .NCH(2), .SATURATE(1), .RESET_V(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .ld(ld), .ld_val(ld_val),
    .out(out_b), .out_q(out_q_b), .v_o(v_b), .imp_o(imp_b), .edge_p(edge_b), .inv_err(inv_b));
  dual_track_counter #(.WIDTH(8), .NCH(3), .SATURATE(0), .RESET_V(5)) u_c (
    .clk(clk), .rst(rst), .en(en_c), .dir(dir_c), .ld(ld_c), .ld_val(ld_val_c),
    .out(out_c), .out_q(out_q_c), .v_o(v_c), .imp_o(imp_c), .edge_p(edge_c), .inv_err(inv_c));

  typedef struct packed {
    logic [7:0]  va, qa, vb, qb;
    logic [1:0]  ea, eb;
    logic [23:0] vc, qc;
    logic [2:0]  ec;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int mav[2], maq[2], mbv[2], mbq[2], mcv[3], mcq[3];
  bit mae[2], mbe[2], mce[3];

  task automatic nxt(input int w, input int sat, input int rv, input int cur,
                     input bit r, input bit l, input bit e, input bit d, input int lv,
                     output int nv, output bit ne);
    int mx;
    mx = (1 << w) - 1;
    ne = 1'b0;
    nv = cur;
    if (r) nv = rv;
    else if (l) nv = lv;
    else if (e && d) begin
      if (cur == mx) begin ne = 1'b1; nv = sat ? mx : 0; end
      else nv = cur + 1;
    end else if (e) begin
      if (cur == 0) begin ne = 1'b1; nv = sat ? 0 : mx; end
      else nv = cur - 1;
    end
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    exp_t e, got;
    int nv;
    bit ne;
    logic [7:0] ia, ib;
    logic [23:0] ic;
    for (int c = 0; c < 2; c++) begin
      nxt(4, 0, 0, mav[c], rst, ld[c], en[c], dir[c], int'(ld_val[c*4 +: 4]), nv, ne);
      maq[c] = rst ? 0 : mav[c]; mav[c] = nv; mae[c] = ne;
      nxt(4, 1, 0, mbv[c], rst, ld[c], en[c], dir[c], int'(ld_val[c*4 +: 4]), nv, ne);
      mbq[c] = rst ? 0 : mbv[c]; mbv[c] = nv; mbe[c] = ne;
      e.va[c*4 +: 4] = 4'(mav[c]); e.qa[c*4 +: 4] = 4'(maq[c]); e.ea[c] = mae[c];
      e.vb[c*4 +: 4] = 4'(mbv[c]); e.qb[c*4 +: 4] = 4'(mbq[c]); e.eb[c] = mbe[c];
    end
    for (int c = 0; c < 3; c++) begin
      nxt(8, 0, 5, mcv[c], rst, ld_c[c], en_c[c], dir_c[c], int'(ld_val_c[c*8 +: 8]), nv, ne);
      mcq[c] = rst ? 5 : mcv[c]; mcv[c] = nv; mce[c] = ne;
      e.vc[c*8 +: 8] = 8'(mcv[c]); e.qc[c*8 +: 8] = 8'(mcq[c]); e.ec[c] = mce[c];
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d expected 1", sb_q.size());
    end
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      ia = ~got.va; ib = ~got.vb; ic = ~got.vc;
      chk("v_a", v_a, got.va);       chk("imp_a", imp_a, ia);
      chk("out_a", out_a, got.va);   chk("out_q_a", out_q_a, got.qa);
      chk("edge_a", edge_a, got.ea); chk("inv_a", inv_a, 0);
      chk("v_b", v_b, got.vb);       chk("imp_b", imp_b, ib);
      chk("out_b", out_b, got.vb);   chk("out_q_b", out_q_b, got.qb);
      chk("edge_b", edge_b, got.eb); chk("inv_b", inv_b, 0);
      chk("v_c", v_c, got.vc);       chk("imp_c", imp_c, ic);
      chk("out_c", out_c, got.vc);   chk("out_q_c", out_q_c, got.qc);
      chk("edge_c", edge_c, got.ec); chk("inv_c", inv_c, 0);
    end
  endtask

  initial begin
    foreach (mav[i]) begin mav[i] = 0; maq[i] = 0; mbv[i] = 0; mbq[i] = 0; end
    foreach (mcv[i]) begin mcv[i] = 0; mcq[i] = 0; end
    rst = 1'b1; en = '0; dir = '0; ld = '0; ld_val = '0;
    en_c = '0; dir_c = '0; ld_c = '0; ld_val_c = '0;
    #1;
    // reset
    step();
    rst = 1'b0;
    // ch0 counts up through the wrap / saturation point
    en = 2'b01; dir = 2'b01;
    repeat (16) step();
    en = '0;
    step();
    // ch1 loaded to 2 then counted down past zero
    ld = 2'b10; ld_val = {4'd2, 4'd0};
    step();
    ld = '0; en = 2'b10; dir = 2'b00;
    repeat (4) step();
    // load beats a simultaneous up-count
    en = 2'b01; dir = 2'b01; ld = 2'b01; ld_val = {4'd0, 4'd9};
    step();
    // reset in the middle of a count, then resume
    ld = 2'b01; ld_val = {4'd0, 4'd7};
    step();
    ld = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    // random sweep across all instances
    repeat (10000) begin
      rst      = ($urandom_range(0, 499) == 0);
      en       = 2'($urandom);
      dir      = 2'($urandom);
      ld       = 2'($urandom_range(0, 7) == 0 ? $urandom : 0);
      ld_val   = 8'($urandom);
      en_c     = 3'($urandom);
      dir_c    = 3'($urandom);
      ld_c     = 3'($urandom_range(0, 7) == 0 ? $urandom : 0);
      ld_val_c = 24'($urandom);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_track_counter.md
# dual_track_counter

Parametrised multi-channel counter with an explicit architectural state `v` and an implicit micro-architectural shadow `imp`; the design invariant `v + imp == MAX` (MAX = 2^WIDTH-1) holds every cycle. It generalises the single 4-bit up-counter used in our invariant-synthesis test designs by adding:
- configurable width and channel count
- up/down counting, parallel load and saturate/wrap mode
- a registered output stage and a sticky invariant-violation flag

It sits under the verification wrapper as the implementation model compared against the ILA counter state.

## Interface
- `WIDTH`, 4: bits per channel; MAX = 2^WIDTH-1.
- `NCH`, 2: number of independent channels.
- `SATURATE`, 0: 0 = wrap modulo 2^WIDTH; 1 = clamp at 0/MAX.
- `RESET_V`, 0: reset value of every channel's `v`, in the range 0..MAX.

- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  NCH  per-channel count enable.
- `dir`  in  NCH  per-channel direction; 1 = up, 0 = down.
- `ld`  in  NCH  per-channel parallel load.
- `ld_val`  in  NCH*WIDTH  load values; channel c uses bits [c*WIDTH +: WIDTH].
- `out`  out  NCH*WIDTH  combinational `v & (MAX - imp)` per channel.
- `out_q`  out  NCH*WIDTH  `out` registered one cycle.
- `v_o`  out  NCH*WIDTH  current `v` (observation tap).
- `imp_o`  out  NCH*WIDTH  current `imp` (observation tap).
- `edge_p`  out  NCH  one-cycle pulse, registered: previous update wrapped (SATURATE=0) or was clamped (SATURATE=1).
- `inv_err`  out  1  sticky; set when any channel has `v + imp != MAX`.

## Operation
Each channel c is independent. Per-cycle update priority is rst > ld > en.

- **rst:**
  - `v`=RESET_V, `imp`=MAX-RESET_V.
  - `out_q`=RESET_V in every channel; `edge_p`=0; `inv_err`=0.
- **ld[c]:** `v`=ld_val[c], `imp`=MAX-ld_val[c]. `en`/`dir` are ignored. `edge_p[c]` next = 0.
- **en[c] & dir[c] (up):**
  - Normal case: `v`=v+1, `imp`=imp-1.
  - At v==MAX with SATURATE=0: `v`=0, `imp`=MAX; `edge_p[c]` next = 1.
  - At v==MAX with SATURATE=1: `v` and `imp` hold; `edge_p[c]` next = 1.
- **en[c] & ~dir[c] (down):**
  - Normal case: `v`=v-1, `imp`=imp+1.
  - At v==0 with SATURATE=0: `v`=MAX, `imp`=0; `edge_p[c]` next = 1.
  - At v==0 with SATURATE=1: hold; `edge_p[c]` next = 1.
- **Idle (no ld, no en):** hold `v` and `imp`; `edge_p[c]` next = 0.
- **Arithmetic:** all arithmetic is WIDTH bits, unsigned, and truncated. `imp` is updated from its own register, never derived from `v`, so the invariant is a provable property rather than a tautology.
- **out:** equals `v` whenever the invariant holds.
- **inv_err:**
  - Registered: set on the clock edge after any channel's combinational check `v + imp != MAX` (WIDTH-bit sum) is true.
  - Cleared only by `rst`.
  - Unreachable in correct RTL; it exists as an assertion target.

## Timing
- **Update latency:** `v_o`, `imp_o` and `out` reflect an `en`/`ld` one cycle after the sampling edge.
- **out_q:** lags `out` by one further cycle, i.e. 2 cycles from stimulus.
- **edge_p:** asserted in the same cycle that `v_o` shows the wrapped or held value. Width is exactly one cycle unless the boundary event repeats (e.g. saturated and enabled continuously, in which case it stays high).
- **Simultaneous ld and en:** ld wins; no edge_p.
- **Reset:** `rst` mid-operation takes effect at the next edge regardless of `en`/`ld`; the outputs take reset values in the following cycle.
- **Interfaces:** no handshake; inputs are sampled every cycle with no back-pressure.

## Test plan
- **Reset:** WIDTH=4, NCH=2, RESET_V=0. Assert rst 1 cycle -> v_o=0,0; imp_o=F,F; out=0; out_q=0; edge_p=0; inv_err=0.
- **Wrap up:** SATURATE=0, ch0 en=1, dir=1 for 16 cycles -> v_o[0] runs 1..F,0. edge_p[0] high only in the cycle v_o[0]=0. out_q[0] trails out[0] by 1 cycle. ch1 unchanged.
- **Saturate down:** SATURATE=1, ld ch1=2, then en=1, dir=0 for 4 cycles -> v_o[1]=1,0,0,0; imp_o[1]=E,F,F,F; edge_p[1]=0,0,1,1.
- **Load priority:** ld[0]=1, ld_val=9, with en=1, dir=1 in the same cycle -> v_o[0]=9, imp_o[0]=6, edge_p[0]=0.
- **Reset mid-count:** ch0 at v=7 counting up, rst pulsed 1 cycle -> next cycle v_o[0]=0, imp_o[0]=F, out_q=0. Counting resumes from 0 after rst deasserts.
- **Invariant sweep:** random en/dir/ld over 10k cycles for WIDTH=4 and WIDTH=8, NCH=3 -> inv_err stays 0; out==v_o for every channel every cycle.
